// File: rtl/vdp1_color_calc_pipe.sv
// vdp1_color_calc_pipe: pipelined VDP1 colour-calculation unit, LANES pixels per beat.
// Optional feature macro: VDP1_CC_SATURATE_EN
//   defined   -> Gouraud add clamps each channel to [0,31]
//   undefined -> Gouraud add wraps to the low 5 bits (legacy behaviour)
// STAGES=2: s0 holds inputs, output register holds the resolved pixel.
// STAGES=3: an extra middle register holds the Gouraud sums before mode selection.
module vdp1_color_calc_pipe #(
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 18,
  parameter int G_BIAS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_ccb,
  input  logic [16*LANES-1:0]   in_orig,
  input  logic [16*LANES-1:0]   in_back,
  input  logic [15*LANES-1:0]   in_gour,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*LANES-1:0]   out_pix,
  output logic [TAG_W-1:0]      out_tag
);

  // Gouraud add on one 5-bit channel: c + g - G_BIAS.
  function automatic logic [4:0] g_chan(input logic [4:0] c, input logic [4:0] g);
    logic [4:0] res;
`ifdef VDP1_CC_SATURATE_EN
    logic signed [6:0] sum;
    sum = $signed({2'b00, c}) + $signed({2'b00, g}) - $signed(7'(G_BIAS));
    if (sum < 7'sd0)       res = 5'd0;
    else if (sum > 7'sd31) res = 5'd31;
    else                   res = sum[4:0];
`else
    // Modulo-32 arithmetic gives the low 5 bits of the signed sum directly.
    res = c + g - 5'(G_BIAS);
`endif
    return res;
  endfunction

  // Gouraud add on a packed {B,G,R} triple.
  function automatic logic [14:0] g_pix(input logic [14:0] c, input logic [14:0] g);
    logic [14:0] r;
    for (int ch = 0; ch < 3; ch++) r[ch*5 +: 5] = g_chan(c[ch*5 +: 5], g[ch*5 +: 5]);
    return r;
  endfunction

  // Halve every channel of a packed {B,G,R} triple.
  function automatic logic [14:0] h_pix(input logic [14:0] x);
    return {1'b0, x[14:11], 1'b0, x[9:6], 1'b0, x[4:1]};
  endfunction

  // Half-transparent blend. Each halved channel is at most 15, so the per-channel
  // sums never exceed 30 and a single 15-bit add cannot carry across channels.
  function automatic logic [14:0] ht_pix(input logic [14:0] a, input logic [14:0] b);
    return h_pix(a) + h_pix(b);
  endfunction

  // Final mode selection for one pixel; gp is G(O) already computed.
  function automatic logic [15:0] mode_pix(input logic [2:0] ccb, input logic [15:0] o,
                                           input logic [15:0] b, input logic [14:0] gp);
    logic [15:0] r;
    case (ccb)
      3'b000:  r = o;
      3'b001:  r = b[15] ? {1'b1, h_pix(b[14:0])} : b;
      3'b010:  r = {o[15], h_pix(o[14:0])};
      3'b011:  r = b[15] ? {o[15], ht_pix(o[14:0], b[14:0])} : o;
      3'b100:  r = {o[15], gp};
      3'b101:  r = b;
      3'b110:  r = {o[15], h_pix(gp)};
      default: r = b[15] ? {o[15], ht_pix(gp, b[14:0])} : {o[15], gp};
    endcase
    return r;
  endfunction

  logic                  s0_valid_q, s0_valid_d;
  logic [2:0]            s0_ccb_q, s0_ccb_d;
  logic [16*LANES-1:0]   s0_orig_q, s0_orig_d;
  logic [16*LANES-1:0]   s0_back_q, s0_back_d;
  logic [15*LANES-1:0]   s0_gour_q, s0_gour_d;
  logic [TAG_W-1:0]      s0_tag_q, s0_tag_d;
  logic                  out_valid_q, out_valid_d;
  logic [16*LANES-1:0]   out_pix_q, out_pix_d;
  logic [TAG_W-1:0]      out_tag_q, out_tag_d;

  logic                  last_ready;
  logic                  s0_next_ready;
  logic [15*LANES-1:0]   g_s0;
  logic                  f_valid;
  logic [2:0]            f_ccb;
  logic [16*LANES-1:0]   f_orig, f_back, f_pix;
  logic [15*LANES-1:0]   f_gp;
  logic [TAG_W-1:0]      f_tag;

  // Ready chain: a stage may load when it is empty or its content is leaving.
  assign last_ready = !out_valid_q || out_ready;
  assign in_ready   = !s0_valid_q || s0_next_ready;

  // Gouraud sums from the input stage, one per lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : gen_g
    assign g_s0[gi*15 +: 15] = g_pix(s0_orig_q[gi*16 +: 15], s0_gour_q[gi*15 +: 15]);
  end

  if (STAGES == 3) begin : gen_s3
    logic                s1_valid_q, s1_valid_d;
    logic [2:0]          s1_ccb_q, s1_ccb_d;
    logic [16*LANES-1:0] s1_orig_q, s1_orig_d;
    logic [16*LANES-1:0] s1_back_q, s1_back_d;
    logic [15*LANES-1:0] s1_gp_q, s1_gp_d;
    logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
    logic                mid_ready;

    assign mid_ready     = !s1_valid_q || last_ready;
    assign s0_next_ready = mid_ready;

    // Middle stage captures the Gouraud sums when it can accept from s0.
    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_ccb_d   = s1_ccb_q;
      s1_orig_d  = s1_orig_q;
      s1_back_d  = s1_back_q;
      s1_gp_d    = s1_gp_q;
      s1_tag_d   = s1_tag_q;
      if (mid_ready) begin
        s1_valid_d = s0_valid_q;
        if (s0_valid_q) begin
          s1_ccb_d  = s0_ccb_q;
          s1_orig_d = s0_orig_q;
          s1_back_d = s0_back_q;
          s1_gp_d   = g_s0;
          s1_tag_d  = s0_tag_q;
        end
      end
    end

    // Middle stage registers; in-flight beats are discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_ccb_q   <= '0;
        s1_orig_q  <= '0;
        s1_back_q  <= '0;
        s1_gp_q    <= '0;
        s1_tag_q   <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_ccb_q   <= s1_ccb_d;
        s1_orig_q  <= s1_orig_d;
        s1_back_q  <= s1_back_d;
        s1_gp_q    <= s1_gp_d;
        s1_tag_q   <= s1_tag_d;
      end
    end

    assign f_valid = s1_valid_q;
    assign f_ccb   = s1_ccb_q;
    assign f_orig  = s1_orig_q;
    assign f_back  = s1_back_q;
    assign f_gp    = s1_gp_q;
    assign f_tag   = s1_tag_q;
  end else begin : gen_s2
    assign s0_next_ready = last_ready;
    assign f_valid = s0_valid_q;
    assign f_ccb   = s0_ccb_q;
    assign f_orig  = s0_orig_q;
    assign f_back  = s0_back_q;
    assign f_gp    = g_s0;
    assign f_tag   = s0_tag_q;
  end

  // Mode selection feeding the output register, one per lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : gen_mode
    assign f_pix[gi*16 +: 16] = mode_pix(f_ccb, f_orig[gi*16 +: 16], f_back[gi*16 +: 16],
                                         f_gp[gi*15 +: 15]);
  end

  // Input stage samples the bus only on an accepted beat.
  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_ccb_d   = s0_ccb_q;
    s0_orig_d  = s0_orig_q;
    s0_back_d  = s0_back_q;
    s0_gour_d  = s0_gour_q;
    s0_tag_d   = s0_tag_q;
    if (in_ready) begin
      s0_valid_d = in_valid;
      if (in_valid) begin
        s0_ccb_d  = in_ccb;
        s0_orig_d = in_orig;
        s0_back_d = in_back;
        s0_gour_d = in_gour;
        s0_tag_d  = in_tag;
      end
    end
  end

  // Output stage loads when empty or consumed, otherwise holds the result stable.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    out_tag_d   = out_tag_q;
    if (last_ready) begin
      out_valid_d = f_valid;
      if (f_valid) begin
        out_pix_d = f_pix;
        out_tag_d = f_tag;
      end
    end
  end

  // Input and output stage registers; in-flight beats are discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q  <= 1'b0;
      s0_ccb_q    <= '0;
      s0_orig_q   <= '0;
      s0_back_q   <= '0;
      s0_gour_q   <= '0;
      s0_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_tag_q   <= '0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_ccb_q    <= s0_ccb_d;
      s0_orig_q   <= s0_orig_d;
      s0_back_q   <= s0_back_d;
      s0_gour_q   <= s0_gour_d;
      s0_tag_q    <= s0_tag_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_tag   = out_tag_q;

endmodule
